capture_sched: RTL
==================

# capture_sched

Capture scheduler that sequences the ADC capture buffer in the 125 MHz logic domain. It issues `start_buff` pulses to the capture buffer on a manual trigger, on a programmable period, or back-to-back. It tracks the outgoing UDP payload stream so a new capture never starts before the previous one has fully drained. It sits between the debounced button / MicroBlaze control bits and the capture buffer, observing the buffer-to-UDP AXI-stream.

## Interface
- `PERIOD_W`, 32: width of `period`.
- `PKTS_PER_CAP`, 16: number of `tlast` packets that make up one capture.
- `TIMEOUT_CYC`, 1_000_000: drain-stall limit in `clk` cycles (8 ms).

Ports:
- `clk`  in  1: 125 MHz logic clock; the only clock.
- `reset`  in  1: synchronous, active-high reset.
- `aligned`  in  1: ADC deserializer aligned; already synchronized to `clk`.
- `trig_tick`  in  1: one-cycle manual trigger (debounced edge).
- `mode`  in  2: `00` off, `01` single, `10` periodic, `11` continuous.
- `period`  in  `PERIOD_W`: cycles between periodic start pulses; values <4 are treated as 4.
- `tvalid`, `tready`, `tlast`  in  1 each: monitor taps on the UDP TX payload stream.
- `start_buff`  out  1: one-cycle capture start to the buffer.
- `busy`  out  1: capture in flight.
- `cap_count`  out  16: completed captures; wraps at 0xFFFF→0.
- `timeout_err`  out  1: sticky drain-stall flag.

## Operation
States: IDLE, ARMED, START, DRAIN.
- IDLE: entered when `mode==00` or `!aligned`. Goes to ARMED when `mode!=00 && aligned`.
- ARMED: behaviour depends on `mode`.
  - single: on `trig_tick`, go to START.
  - periodic: when `timer >= period-1`, go to START.
  - continuous: go to START unconditionally.
  - If `mode==00` or `!aligned`, go to IDLE.
- START: one cycle; `start_buff=1`; packet counter cleared; `timer` cleared to 0. Always goes to DRAIN.
- DRAIN: a beat is `tvalid&tready&tlast`. Each beat increments the packet counter. The beat that brings the count to `PKTS_PER_CAP` increments `cap_count` and moves to ARMED.
- `timer`: counts cycles since the last START (0 in the START cycle), increments every cycle, and saturates at all-ones.
- `busy` = state is START or DRAIN.
- `trig_tick` outside ARMED/single is dropped, not queued.
- `mode` or `aligned` changes during DRAIN do not abort the drain. They take effect in ARMED, which then exits to IDLE if required.
- `tlast` beats in IDLE/ARMED/START are ignored; they do not count toward the next capture.
- `timeout_err` is cleared by `reset` or by `mode==00`.

## Timing
- All outputs are registered. Reset values: state IDLE, `start_buff=0`, `busy=0`, `cap_count=0`, `timeout_err=0`, `timer=0`, packet counter 0.
- Single mode: `trig_tick` at cycle t gives `start_buff` at t+1 and `busy` from t+1.
- Continuous mode: final `tlast` beat at t gives ARMED at t+1 and `start_buff` at t+2.
- Periodic mode: pulse spacing is exactly `period` cycles when the drain completes before `timer` reaches `period-2`. Otherwise the next pulse comes 2 cycles after the final beat.
- `cap_count` updates in the cycle after the final beat.
- `reset` mid-DRAIN returns to IDLE next cycle with no pulse and no count.

## Configuration
- `CAPTURE_SCHED_TIMEOUT_EN` defined:
  - In DRAIN, a stall counter clears on every `tlast` beat and increments otherwise.
  - When it reaches `TIMEOUT_CYC`, `timeout_err` is set, `cap_count` is not incremented, and the state moves to ARMED.
- Undefined:
  - No stall counter; DRAIN waits indefinitely.
  - `timeout_err` is tied to 0.

## Test plan
- Reset, then `aligned=1`, `mode=01`, pulse `trig_tick` at cycle 10, then drive 16 `tlast` beats. Required: `start_buff` at 11 only; `busy` 11 until the cycle after the 16th beat; `cap_count=1`.
- `mode=10`, `period=1000`, each capture drains in 200 cycles, run 5 captures. Required: pulses exactly 1000 cycles apart; `cap_count=5`.
- `mode=11`, drain 16 beats. Required: next `start_buff` 2 cycles after the final beat. A `trig_tick` injected during DRAIN produces no extra pulse.
- `aligned` dropped after beat 5 of 16. Required: drain completes, `cap_count` increments, state goes to IDLE, and no further pulse occurs.
- With the timeout macro and `TIMEOUT_CYC=100`: 3 beats, then stall. Required: `timeout_err=1` at 100 stalled cycles, `cap_count` unchanged, re-arm follows; `mode=00` clears the flag.
- `cap_count` preset to 0xFFFF by running captures. Required: the next completion gives 0x0000.

Source files
------------

// File: rtl/capture_sched.sv
// Capture scheduler: issues start_buff pulses (single / periodic / continuous) and waits for the
// capture's tlast packets to drain before re-arming. Optional macro CAPTURE_SCHED_TIMEOUT_EN adds a drain-stall timeout.
module capture_sched #(
  parameter int PERIOD_W     = 32,
  parameter int PKTS_PER_CAP = 16,
  parameter int TIMEOUT_CYC  = 1_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                aligned,
  input  logic                trig_tick,
  input  logic [1:0]          mode,
  input  logic [PERIOD_W-1:0] period,
  input  logic                tvalid,
  input  logic                tready,
  input  logic                tlast,
  output logic                start_buff,
  output logic                busy,
  output logic [15:0]         cap_count,
  output logic                timeout_err
);

  localparam int PKT_W = $clog2(PKTS_PER_CAP + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_START, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic [PERIOD_W-1:0] period_eff, period_m1;
  logic [PKT_W-1:0]    pkt_q, pkt_d;
  logic [15:0]         cap_q, cap_d;
  logic                start_q, busy_q;
  logic                err_q, err_d;
  logic                enabled, fire, beat, last_beat, timeout_hit;

  assign enabled    = (mode != 2'b00) && aligned;
  assign beat       = tvalid & tready & tlast;
  assign last_beat  = beat && (pkt_q == PKT_W'(PKTS_PER_CAP - 1));
  assign period_eff = (period < PERIOD_W'(4)) ? PERIOD_W'(4) : period;
  assign period_m1  = period_eff - PERIOD_W'(1);

  always_comb begin
    fire = 1'b0;
    case (mode)
      2'b01:   fire = trig_tick;
      2'b10:   fire = (timer_q >= period_m1);
      2'b11:   fire = 1'b1;
      default: fire = 1'b0;
    endcase
  end

`ifdef CAPTURE_SCHED_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

  logic [STALL_W-1:0] stall_q, stall_d;

  // Stall counter only runs while draining; any tlast beat restarts the window.
  always_comb begin
    stall_d     = stall_q;
    timeout_hit = 1'b0;
    if (state_q == S_START) begin
      stall_d = '0;
    end else if (state_q == S_DRAIN) begin
      if (beat) begin
        stall_d = '0;
      end else begin
        timeout_hit = (stall_q == STALL_W'(TIMEOUT_CYC - 1));
        stall_d     = stall_q + STALL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    cap_d   = cap_q;
    err_d   = err_q;
    timer_d = (&timer_q) ? timer_q : timer_q + PERIOD_W'(1);
    case (state_q)
      S_IDLE: begin
        if (enabled) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!enabled)  state_d = S_IDLE;
        else if (fire) state_d = S_START;
      end
      S_START: begin
        pkt_d   = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (beat) pkt_d = pkt_q + PKT_W'(1);
        if (last_beat) begin
          cap_d   = cap_q + 16'd1;
          state_d = S_ARMED;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_ARMED;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Timer reads 0 in the START cycle itself, so clear on entry.
    if (state_d == S_START) timer_d = '0;
    if (mode == 2'b00)      err_d   = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      pkt_q   <= '0;
      cap_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pkt_q   <= pkt_d;
      cap_q   <= cap_d;
      err_q   <= err_d;
      start_q <= (state_d == S_START);
      busy_q  <= (state_d == S_START) || (state_d == S_DRAIN);
    end
  end

  assign start_buff  = start_q;
  assign busy        = busy_q;
  assign cap_count   = cap_q;
  assign timeout_err = err_q;

endmodule
